// File: rtl/b_comp.sv
// rtl/b_comp.sv - three-input bit-equality comparator with registered status and optional statistics
// Optional statistics (sticky, first, cnt) are built only when BCOMP_STATS_EN is defined.
module b_comp #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             clr,
    output logic             F,
    output logic             all_one,
    output logic             maj,
    output logic             F_q,
    output logic             sticky,
    output logic [2:0]       first,
    output logic [CNT_W-1:0] cnt
);

    // Combinational outputs must stay usable with the clock stopped.
    assign F       = (A ^ B) | (B ^ C);
    assign all_one = A & B & C;
    assign maj     = (A & B) | (A & C) | (B & C);

    logic f_q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q_q <= 1'b0;
        end else begin
            f_q_q <= F;
        end
    end

    assign F_q = f_q_q;

`ifdef BCOMP_STATS_EN
    logic             sticky_q, sticky_d;
    logic [2:0]       first_q, first_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear takes priority over a disagreement on the same edge.
    always_comb begin
        sticky_d = sticky_q;
        first_d  = first_q;
        cnt_d    = cnt_q;
        if (clr) begin
            sticky_d = 1'b0;
            first_d  = 3'b000;
            cnt_d    = '0;
        end else if (F) begin
            sticky_d = 1'b1;
            if (!sticky_q) begin
                first_d = {A, B, C};
            end
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 1'b0;
            first_q  <= 3'b000;
            cnt_q    <= '0;
        end else begin
            sticky_q <= sticky_d;
            first_q  <= first_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sticky = sticky_q;
    assign first  = first_q;
    assign cnt    = cnt_q;
`else
    logic unused_clr;
    assign unused_clr = clr;
    assign sticky     = 1'b0;
    assign first      = 3'b000;
    assign cnt        = '0;
`endif

endmodule

// File: tb/tb_b_comp.sv
// tb/tb_b_comp.sv - scoreboard testbench for b_comp
module tb_b_comp;

    localparam int CNT_W = 4;
`ifdef BCOMP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             clk_en = 1'b1;
    logic             rst = 1'b1;
    logic             A = 1'b0, B = 1'b0, C = 1'b0, clr = 1'b0;
    logic             F, all_one, maj, F_q, sticky;
    logic [2:0]       first;
    logic [CNT_W-1:0] cnt;

    b_comp #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .clr(clr),
        .F(F), .all_one(all_one), .maj(maj), .F_q(F_q),
        .sticky(sticky), .first(first), .cnt(cnt)
    );

    always #5 if (clk_en) clk = ~clk;

    typedef enum int {K_F, K_MAJ, K_ALL1, K_FQ, K_STICKY, K_FIRST, K_CNT} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] exp;
        string       name;
    } item_t;

    item_t q[$];
    event  sample_ev;
    int    n_run = 0;
    int    n_fail = 0;

    function automatic logic [31:0] actual(input kind_t k);
        case (k)
            K_F:      return {31'd0, F};
            K_MAJ:    return {31'd0, maj};
            K_ALL1:   return {31'd0, all_one};
            K_FQ:     return {31'd0, F_q};
            K_STICKY: return {31'd0, sticky};
            K_FIRST:  return {29'd0, first};
            default:  return {{(32-CNT_W){1'b0}}, cnt};
        endcase
    endfunction

    initial begin
        item_t it;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            while (q.size() > 0) begin
                it  = q.pop_front();
                act = actual(it.kind);
                n_run++;
                if (act !== it.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %0d expected %0d", it.name, act, it.exp);
                end
            end
        end
    end

    task automatic expect_val(input kind_t k, input logic [31:0] v, input string nm);
        item_t it;
        it.kind = k;
        it.exp  = v;
        it.name = nm;
        q.push_back(it);
    endtask

    task automatic sample();
        -> sample_ev;
        #1;
    endtask

    task automatic step(input logic [2:0] abc, input logic c_clr);
        @(negedge clk);
        {A, B, C} = abc;
        clr = c_clr;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_stats(input logic s, input logic [2:0] f, input int c, input string tag);
        expect_val(K_STICKY, STATS ? {31'd0, s} : 32'd0, {tag, "_sticky"});
        expect_val(K_FIRST,  STATS ? {29'd0, f} : 32'd0, {tag, "_first"});
        expect_val(K_CNT,    STATS ? c : 0,              {tag, "_cnt"});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] f_tab, maj_tab, all_tab;
        f_tab   = 8'b0111_1110;
        maj_tab = 8'b1110_1000;
        all_tab = 8'b1000_0000;

        @(posedge clk);
        #1;
        expect_val(K_FQ, 0, "rst_fq");
        expect_stats(1'b0, 3'b000, 0, "rst");
        sample();
        n_run++;
        if (F_q !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_fq_direct: got %0d expected 0", F_q);
        end
        @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        clk_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            {A, B, C} = 3'(i);
            #1;
            expect_val(K_F,    {31'd0, f_tab[i]},   $sformatf("comb_f_%0d", i));
            expect_val(K_MAJ,  {31'd0, maj_tab[i]}, $sformatf("comb_maj_%0d", i));
            expect_val(K_ALL1, {31'd0, all_tab[i]}, $sformatf("comb_all1_%0d", i));
            sample();
        end
        expect_val(K_FQ, 0, "idle_fq");
        expect_stats(1'b0, 3'b000, 0, "idle");
        sample();
        {A, B, C} = 3'b000;
        clk_en = 1'b1;

        step(3'b011, 1'b0);
        expect_val(K_FQ, 1, "reg_fq_011");
        sample();
        n_run++;
        if (F_q !== 1'b1) begin
            n_fail++;
            $display("FAIL reg_fq_011_direct: got %0d expected 1", F_q);
        end
        step(3'b000, 1'b0);
        expect_val(K_FQ, 0, "reg_fq_000");
        sample();
        n_run++;
        if (F_q !== 1'b0) begin
            n_fail++;
            $display("FAIL reg_fq_000_direct: got %0d expected 0", F_q);
        end

        do_reset();
        step(3'b000, 1'b0);
        step(3'b101, 1'b0);
        step(3'b110, 1'b0);
        step(3'b111, 1'b0);
        expect_stats(1'b1, 3'b101, 2, "seq");
        expect_val(K_FQ, 0, "seq_fq");
        sample();

        for (int i = 0; i < 20; i++) step(3'b011, 1'b0);
        expect_stats(1'b1, 3'b101, 15, "sat");
        sample();

        step(3'b001, 1'b1);
        expect_stats(1'b0, 3'b000, 0, "clr");
        expect_val(K_FQ, 1, "clr_fq");
        sample();
        step(3'b001, 1'b0);
        expect_stats(1'b1, 3'b001, 1, "post_clr");
        sample();

        do_reset();
        for (int i = 0; i < 5; i++) step(3'b011, 1'b0);
        expect_stats(1'b1, 3'b011, 5, "pre_arst");
        sample();
        #1;
        rst = 1'b1;
        #1;
        expect_stats(1'b0, 3'b000, 0, "arst");
        expect_val(K_FQ, 0, "arst_fq");
        expect_val(K_F,  1, "arst_f_011");
        sample();
        n_run++;
        if (cnt !== '0) begin
            n_fail++;
            $display("FAIL arst_cnt_direct: got %0d expected 0", cnt);
        end
        n_run++;
        if (F_q !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_fq_direct: got %0d expected 0", F_q);
        end
        {A, B, C} = 3'b000;
        #1;
        expect_val(K_F,    0, "arst_f_000");
        expect_val(K_ALL1, 0, "arst_all1_000");
        sample();
        {A, B, C} = 3'b111;
        #1;
        expect_val(K_ALL1, 1, "arst_all1_111");
        expect_val(K_MAJ,  1, "arst_maj_111");
        sample();
        @(negedge clk);
        rst = 1'b0;

        #2;
        sample();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        if (n_fail != 0) begin
            $display("FAIL summary: got %0d failures expected 0", n_fail);
        end
        $finish;
    end

endmodule
